// File: rtl/stall_ctrl_if.sv
// Handshake bundle between the D/E pipeline stages and the hazard/stall controller.
// The controller takes the slave modport; the driving pipeline (or bench) takes master.
interface stall_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] Tuse_rs_D;
    logic [1:0] Tuse_rt_D;
    logic       md_use_D;
    logic [1:0] Tnew_E;
    logic [4:0] Num_new_E;
    logic       md_start_E;
    logic       md_div_E;
    logic       stall;
    logic       en_PC;
    logic       en_D;
    logic       flush_E;
    logic [1:0] Tnew_M;
    logic [4:0] Num_new_M;
    logic       md_busy;

    modport slave (
        input  rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, md_use_D,
        input  Tnew_E, Num_new_E, md_start_E, md_div_E,
        output stall, en_PC, en_D, flush_E, Tnew_M, Num_new_M, md_busy
    );

    modport master (
        output rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, md_use_D,
        output Tnew_E, Num_new_E, md_start_E, md_div_E,
        input  stall, en_PC, en_D, flush_E, Tnew_M, Num_new_M, md_busy
    );
endinterface

// File: rtl/stall_ctrl.sv
// Consumer-side hazard detection: compares D-stage source use times against E and M
// producer records, and holds HI/LO users in D while the multiply/divide unit is busy.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic         clk,
    input logic         reset,
    stall_ctrl_if.slave bus
);

    logic [3:0] cnt_q, cnt_d;
    logic [1:0] tnew_m_q, tnew_m_d;
    logic [4:0] num_m_q;
    logic       reg_stall;
    logic       md_stall;

    function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] num, input logic [1:0] tnew);
        return (src != 5'd0) && (src == num) && (tuse != 2'b11) && (tuse < tnew);
    endfunction

    always_comb begin
        reg_stall = hazard(bus.rs_D, bus.Tuse_rs_D, bus.Num_new_E, bus.Tnew_E)
                  | hazard(bus.rt_D, bus.Tuse_rt_D, bus.Num_new_E, bus.Tnew_E)
                  | hazard(bus.rs_D, bus.Tuse_rs_D, num_m_q, tnew_m_q)
                  | hazard(bus.rt_D, bus.Tuse_rt_D, num_m_q, tnew_m_q);
        md_stall  = bus.md_use_D & ((cnt_q != 4'd0) | bus.md_start_E);
    end

    // E always advances into M, even on a stall (E is flushed, not held).
    always_comb begin
        tnew_m_d = (bus.Tnew_E == 2'd0) ? 2'd0 : bus.Tnew_E - 2'd1;
        cnt_d    = cnt_q;
        if (bus.md_start_E) begin
            cnt_d = bus.md_div_E ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 4'd0;
            tnew_m_q <= 2'd0;
            num_m_q  <= 5'd0;
        end else begin
            cnt_q    <= cnt_d;
            tnew_m_q <= tnew_m_d;
            num_m_q  <= bus.Num_new_E;
        end
    end

    assign bus.stall     = reg_stall | md_stall;
    assign bus.en_PC     = ~bus.stall;
    assign bus.en_D      = ~bus.stall;
    assign bus.flush_E   = bus.stall;
    assign bus.Tnew_M    = tnew_m_q;
    assign bus.Num_new_M = num_m_q;
    assign bus.md_busy   = (cnt_q != 4'd0);

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Consumer side of the pipeline hazard protocol. Every E-stage instruction publishes `Tnew_E` and `Num_new_E` as its producer record. This block compares those records, and an M-stage copy it keeps internally, against the D-stage instruction's source registers and use times. It raises a stall that freezes PC/D and flushes E. It also owns the multiply/divide busy counter, so that HI/LO-touching instructions wait in D while the unit is busy.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after mult/multu leaves E.
- `DIV_CYCLES`, default 10: busy cycles after div/divu/fastdiv leaves E.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `rs_D`  in  5  D-stage rs field.
- `rt_D`  in  5  D-stage rt field.
- `Tuse_rs_D`  in  2  cycles until D instruction needs rs; 2'b11 = rs not read.
- `Tuse_rt_D`  in  2  as above for rt.
- `md_use_D`  in  1  D instruction is mult/multu/div/divu/fastdiv/mfhi/mflo/mthi/mtlo.
- `Tnew_E`  in  2  E-stage producer time (0..2).
- `Num_new_E`  in  5  E-stage destination register (0 = none).
- `md_start_E`  in  1  E instruction is mult/multu/div/divu/fastdiv.
- `md_div_E`  in  1  with `md_start_E`: selects `DIV_CYCLES`, else `MULT_CYCLES`.
- `stall`  out  1  hazard detected this cycle.
- `en_PC`  out  1  = ~stall.
- `en_D`  out  1  = ~stall.
- `flush_E`  out  1  = stall; E register loads a nop next edge.
- `Tnew_M`  out  2  registered M-stage producer time.
- `Num_new_M`  out  5  registered M-stage destination.
- `md_busy`  out  1  busy counter nonzero.

## Operation
M-stage record:
- E advances into M every cycle, stalled or not.
- Each edge: `Num_new_M <= Num_new_E`; `Tnew_M <= (Tnew_E==0) ? 0 : Tnew_E-1`.

Register-hazard stall terms, for src ∈ {rs, rt} and stage ∈ {E, M}:
- A term fires when `src_D != 0`, `src_D == Num_new_stage`, `Tuse_src_D != 2'b11` and `Tuse_src_D < Tnew_stage`.
- Unsigned compare.
- A `Num_new` of 0 never stalls.

MD stall term:
- Fires when `md_use_D` is high and (`md_busy` or `md_start_E`) is high.

Stall output:
- `stall` = OR of all terms; purely combinational from inputs and registered state.

Busy counter `cnt` (4 bits, wide enough for `DIV_CYCLES` ≤ 15):
- If `md_start_E`: load `md_div_E ? DIV_CYCLES : MULT_CYCLES`.
- Else if `cnt != 0`: decrement.
- Else: hold.
- `md_busy = (cnt != 0)`.

Boundary cases:
- `md_start_E` while `cnt != 0`: reload; the new operation overrides.
- `md_start_E` with a stall the same cycle: the counter still loads. The E instruction is real and leaves E; only the D instruction is held.
- Both E and M match the same register: either term suffices. No priority is needed; stall is an OR.
- Register 0 as source never stalls, even if `Num_new` is 0.

## Timing
Reset values (asynchronous, effective without clock):
- `cnt`=0, `Tnew_M`=0, `Num_new_M`=0, `md_busy`=0.
- `stall` depends only on E inputs during reset.
- `reset` asserted mid-count aborts the busy period immediately.

Latency:
- `stall` has zero-cycle latency from `*_D`/`*_E` inputs.
- `Tnew_M`/`Num_new_M` lag E by exactly one edge.

Busy window:
- Start in E at cycle t gives `md_busy` high in cycles t+1 … t+N, low at t+N+1.
- A D-stage md instruction is stalled in cycles t … t+N and issues at t+N+1.

Stall cycles for a single producer, `Tuse` < `Tnew_E`:
- Stall holds for `Tnew_E - Tuse` cycles.
- Resolution is through the M record, where the now-decremented Tnew is compared.

## Test plan
- lw→use: `Tnew_E`=2, `Num_new_E`=8, `rs_D`=8, `Tuse_rs_D`=1 → stall=1 in cycle 0. In cycle 1, E is flushed (inputs 0/0), `Tnew_M`=1, `Num_new_M`=8, stall=0.
- lw→beq: same as above but `Tuse_rs_D`=0 → stall=1 in cycles 0 and 1, stall=0 in cycle 2 (`Tnew_M`=0 by then).
- ALU→use: `Tnew_E`=1, `Num_new_E`=5, `rt_D`=5, `Tuse_rt_D`=1 → stall=0. With `Tuse_rt_D`=0 → stall=1 for exactly one cycle.
- $0 and no-use cases: `Num_new_E`=0 with `rs_D`=0 and `Tuse`=0 → stall=0. `Tuse_rs_D`=3 with a matching register → stall=0.
- MD busy: `md_start_E`=1, `md_div_E`=1 at cycle t, followed by an mflo in D (`md_use_D`=1) → stall cycles t..t+10, `md_busy` high t+1..t+10, issue at t+11. Repeat with mult → 5-cycle window.
- Reset at count 4 of a div → `md_busy`=0 and stall=0 (E inputs idle) before the next edge. `Tnew_M` and `Num_new_M` read 0.
